// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered immediate generator with two-entry skid buffer
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [2:0]       in_type,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_type,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);
    localparam logic [2:0] T_U    = 3'd0;
    localparam logic [2:0] T_I    = 3'd1;
    localparam logic [2:0] T_B    = 3'd2;
    localparam logic [2:0] T_J    = 3'd3;
    localparam logic [2:0] T_S    = 3'd4;
    localparam logic [2:0] T_CSR  = 3'd5;
    localparam logic [2:0] T_NONE = 3'd6;
    localparam logic [2:0] T_AUTO = 3'd7;

    logic [2:0]        dec_type;
    logic              dec_illegal;
    logic signed [31:0] dec_sx;
    logic [XLEN-1:0]   dec_imm;

    logic              main_valid;
    logic [XLEN-1:0]   main_imm;
    logic [2:0]        main_type;
    logic              main_illegal;
    logic [TAG_W-1:0]  main_tag;

    logic              skid_valid;
    logic [XLEN-1:0]   skid_imm;
    logic [2:0]        skid_type;
    logic              skid_illegal;
    logic [TAG_W-1:0]  skid_tag;

    logic              accept;
    logic              out_fire;

    always_comb begin
        dec_type    = in_type;
        dec_illegal = 1'b0;
        if (in_type == T_AUTO) begin
            case (in_inst[6:0])
                7'b0110111, 7'b0010111:                         dec_type = T_U;
                7'b1101111:                                     dec_type = T_J;
                7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111: dec_type = T_I;
                7'b1100011:                                     dec_type = T_B;
                7'b0100011:                                     dec_type = T_S;
                7'b0110011:                                     dec_type = T_NONE;
                7'b1110011: dec_type = in_inst[14] ? T_CSR : T_NONE;
                7'b0011011: begin
                    dec_type    = (XLEN == 64) ? T_I : T_NONE;
                    dec_illegal = (XLEN != 64);
                end
                7'b0111011: begin
                    dec_type    = T_NONE;
                    dec_illegal = (XLEN != 64);
                end
                default: begin
                    dec_type    = T_NONE;
                    dec_illegal = 1'b1;
                end
            endcase
        end
    end

    // Every format is first built as a 32-bit signed value; CSR keeps bit 31 clear so it zero-extends.
    always_comb begin
        case (dec_type)
            T_U:     dec_sx = {in_inst[31:12], 12'h000};
            T_I:     dec_sx = {{20{in_inst[31]}}, in_inst[31:20]};
            T_B:     dec_sx = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
            T_J:     dec_sx = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
            T_S:     dec_sx = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            T_CSR:   dec_sx = {27'h0, in_inst[19:15]};
            default: dec_sx = 32'sh0;
        endcase
        dec_imm = XLEN'(dec_sx);
    end

    assign accept   = in_valid & ~skid_valid;
    assign out_fire = main_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid   <= 1'b0;
            main_imm     <= '0;
            main_type    <= T_NONE;
            main_illegal <= 1'b0;
            main_tag     <= '0;
            skid_valid   <= 1'b0;
            skid_imm     <= '0;
            skid_type    <= T_NONE;
            skid_illegal <= 1'b0;
            skid_tag     <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            if (out_fire) begin
                main_imm     <= skid_imm;
                main_type    <= skid_type;
                main_illegal <= skid_illegal;
                main_tag     <= skid_tag;
                skid_valid   <= 1'b0;
            end
        end else if (accept) begin
            if (!main_valid || out_fire) begin
                main_valid   <= 1'b1;
                main_imm     <= dec_imm;
                main_type    <= dec_type;
                main_illegal <= dec_illegal;
                main_tag     <= in_tag;
            end else begin
                skid_valid   <= 1'b1;
                skid_imm     <= dec_imm;
                skid_type    <= dec_type;
                skid_illegal <= dec_illegal;
                skid_tag     <= in_tag;
            end
        end else if (out_fire) begin
            main_valid <= 1'b0;
        end
    end

    assign in_ready    = ~skid_valid;
    assign out_valid   = main_valid;
    assign out_imm     = main_imm;
    assign out_type    = main_type;
    assign out_illegal = main_illegal;
    assign out_tag     = main_tag;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - bench for imm_gen_pipe at XLEN 32 and 64 sharing one stimulus stream
module tb_imm_gen_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_inst, in_tag;
    logic [2:0]  in_type;

    logic        in_ready32, out_valid32, out_illegal32;
    logic [31:0] out_imm32, out_tag32;
    logic [2:0]  out_type32;
    logic        in_ready64, out_valid64, out_illegal64;
    logic [63:0] out_imm64;
    logic [31:0] out_tag64;
    logic [2:0]  out_type64;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
        .in_inst(in_inst), .in_type(in_type), .in_tag(in_tag), .out_valid(out_valid32),
        .out_ready(out_ready), .out_imm(out_imm32), .out_type(out_type32),
        .out_illegal(out_illegal32), .out_tag(out_tag32));

    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .in_inst(in_inst), .in_type(in_type), .in_tag(in_tag), .out_valid(out_valid64),
        .out_ready(out_ready), .out_imm(out_imm64), .out_type(out_type64),
        .out_illegal(out_illegal64), .out_tag(out_tag64));

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  typ;
        logic [31:0] tag;
    } entry_t;

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  typ;
        logic [31:0] imm32;
        logic [2:0]  t32;
        logic        ill32;
        logic [63:0] imm64;
        logic [2:0]  t64;
        logic        ill64;
    } vec_t;

    entry_t     q[$];
    vec_t       tbl[14];
    logic [6:0] ops[14];
    int         vectors = 0;
    int         miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void ref_decode(input logic [31:0] inst, input logic [2:0] typ, input bit x64,
                                       output logic [63:0] imm, output logic [2:0] t, output logic ill);
        logic [6:0] op;
        op  = inst[6:0];
        t   = typ;
        ill = 1'b0;
        if (typ == 3'd7) begin
            if (op == 7'h37 || op == 7'h17) t = 3'd0;
            else if (op == 7'h6F) t = 3'd3;
            else if (op == 7'h67 || op == 7'h03 || op == 7'h13 || op == 7'h0F) t = 3'd1;
            else if (op == 7'h63) t = 3'd2;
            else if (op == 7'h23) t = 3'd4;
            else if (op == 7'h33) t = 3'd6;
            else if (op == 7'h73) t = inst[14] ? 3'd5 : 3'd6;
            else if (x64 && op == 7'h1B) t = 3'd1;
            else if (x64 && op == 7'h3B) t = 3'd6;
            else begin
                t   = 3'd6;
                ill = 1'b1;
            end
        end
        case (t)
            3'd0:    imm = {{32{inst[31]}}, inst[31:12], 12'h0};
            3'd1:    imm = {{52{inst[31]}}, inst[31:20]};
            3'd2:    imm = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            3'd3:    imm = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            3'd4:    imm = {{52{inst[31]}}, inst[31:25], inst[11:7]};
            3'd5:    imm = {59'h0, inst[19:15]};
            default: imm = 64'h0;
        endcase
        if (!x64) imm = {32'h0, imm[31:0]};
    endfunction

    task automatic check_outputs();
        logic [63:0] imm;
        logic [2:0]  t;
        logic        ill;
        chk("in_ready32", in_ready32, q.size() < 2);
        chk("in_ready64", in_ready64, q.size() < 2);
        chk("out_valid32", out_valid32, q.size() > 0);
        chk("out_valid64", out_valid64, q.size() > 0);
        if (q.size() > 0) begin
            ref_decode(q[0].inst, q[0].typ, 1'b0, imm, t, ill);
            chk("imm32", out_imm32, imm);
            chk("type32", out_type32, t);
            chk("illegal32", out_illegal32, ill);
            chk("tag32", out_tag32, q[0].tag);
            ref_decode(q[0].inst, q[0].typ, 1'b1, imm, t, ill);
            chk("imm64", out_imm64, imm);
            chk("type64", out_type64, t);
            chk("illegal64", out_illegal64, ill);
            chk("tag64", out_tag64, q[0].tag);
        end
    endtask

    task automatic check_reset_values();
        chk("rst_valid32", out_valid32, 0);
        chk("rst_valid64", out_valid64, 0);
        chk("rst_ready32", in_ready32, 1);
        chk("rst_ready64", in_ready64, 1);
        chk("rst_type32", out_type32, 6);
        chk("rst_type64", out_type64, 6);
        chk("rst_imm32", out_imm32, 0);
        chk("rst_imm64", out_imm64, 0);
        chk("rst_ill32", out_illegal32, 0);
        chk("rst_tag64", out_tag64, 0);
    endtask

    // Check what the last edge produced, then drive this cycle's inputs and advance the queue model.
    task automatic step(input bit iv, input logic [31:0] inst, input logic [2:0] typ,
                        input logic [31:0] tag, input bit ordy, input bit fl, input bit rs);
        bit can_in, pop;
        entry_t e;
        @(negedge clk);
        check_outputs();
        rst = rs; flush = fl; in_valid = iv; in_inst = inst; in_type = typ; in_tag = tag;
        out_ready = ordy;
        can_in = q.size() < 2;
        pop    = (q.size() > 0) && ordy;
        e      = '{inst, typ, tag};
        if (rs || fl) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (iv && can_in) q.push_back(e);
        end
    endtask

    initial begin
        tbl[0]  = '{32'hFFF00093, 3'd7, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFF_FFFFFFFF, 3'd1, 1'b0};
        tbl[1]  = '{32'h123450B7, 3'd7, 32'h12345000, 3'd0, 1'b0, 64'h00000000_12345000, 3'd0, 1'b0};
        tbl[2]  = '{32'hFE000EE3, 3'd7, 32'hFFFFFFFC, 3'd2, 1'b0, 64'hFFFFFFFF_FFFFFFFC, 3'd2, 1'b0};
        tbl[3]  = '{32'h0080006F, 3'd7, 32'h00000008, 3'd3, 1'b0, 64'h00000000_00000008, 3'd3, 1'b0};
        tbl[4]  = '{32'h3002D073, 3'd7, 32'h00000005, 3'd5, 1'b0, 64'h00000000_00000005, 3'd5, 1'b0};
        tbl[5]  = '{32'h0000007F, 3'd7, 32'h00000000, 3'd6, 1'b1, 64'h00000000_00000000, 3'd6, 1'b1};
        tbl[6]  = '{32'hFFF0009B, 3'd7, 32'h00000000, 3'd6, 1'b1, 64'hFFFFFFFF_FFFFFFFF, 3'd1, 1'b0};
        tbl[7]  = '{32'h0000003B, 3'd7, 32'h00000000, 3'd6, 1'b1, 64'h00000000_00000000, 3'd6, 1'b0};
        tbl[8]  = '{32'h80000F80, 3'd4, 32'hFFFFF81F, 3'd4, 1'b0, 64'hFFFFFFFF_FFFFF81F, 3'd4, 1'b0};
        tbl[9]  = '{32'h0000007F, 3'd6, 32'h00000000, 3'd6, 1'b0, 64'h00000000_00000000, 3'd6, 1'b0};
        tbl[10] = '{32'h00002073, 3'd7, 32'h00000000, 3'd6, 1'b0, 64'h00000000_00000000, 3'd6, 1'b0};
        tbl[11] = '{32'h80000000, 3'd0, 32'h80000000, 3'd0, 1'b0, 64'hFFFFFFFF_80000000, 3'd0, 1'b0};
        tbl[12] = '{32'h00000033, 3'd7, 32'h00000000, 3'd6, 1'b0, 64'h00000000_00000000, 3'd6, 1'b0};
        tbl[13] = '{32'hFFFFFFFF, 3'd5, 32'h0000001F, 3'd5, 1'b0, 64'h00000000_0000001F, 3'd5, 1'b0};
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h0F, 7'h63, 7'h23, 7'h33, 7'h73,
                7'h1B, 7'h3B, 7'h7F};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_type = 3'd7; in_tag = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values();
        rst = 1'b0;

        // Back-to-back table vectors with out_ready held high.
        for (int i = 0; i < 14; i++) begin
            step(1, tbl[i].inst, tbl[i].typ, 32'h100 + i, 1, 0, 0);
            @(posedge clk);
            #1;
            chk("tbl_valid", out_valid32, 1);
            chk("tbl_imm32", out_imm32, tbl[i].imm32);
            chk("tbl_type32", out_type32, tbl[i].t32);
            chk("tbl_ill32", out_illegal32, tbl[i].ill32);
            chk("tbl_imm64", out_imm64, tbl[i].imm64);
            chk("tbl_type64", out_type64, tbl[i].t64);
            chk("tbl_ill64", out_illegal64, tbl[i].ill64);
            chk("tbl_tag", out_tag64, 32'h100 + i);
        end
        step(0, 0, 7, 0, 1, 0, 0);

        // Backpressure: three inputs against a stalled consumer, then drain.
        step(1, 32'h123450B7, 7, 32'hA1, 0, 0, 0);
        step(1, 32'hFE000EE3, 7, 32'hA2, 0, 0, 0);
        step(1, 32'h0080006F, 7, 32'hA3, 0, 0, 0);
        chk("bp_in_ready_low", in_ready32, 0);
        step(1, 32'h0080006F, 7, 32'hA3, 1, 0, 0);
        step(1, 32'h0080006F, 7, 32'hA3, 1, 0, 0);
        step(0, 0, 7, 0, 1, 0, 0);
        step(0, 0, 7, 0, 1, 0, 0);
        chk("bp_drained", out_valid32, 0);

        // Flush with both entries full and a live input.
        step(1, 32'hFFF00093, 7, 32'hB1, 0, 0, 0);
        step(1, 32'h3002D073, 7, 32'hB2, 0, 0, 0);
        step(1, 32'h123450B7, 7, 32'hB3, 1, 1, 0);
        @(posedge clk);
        #1;
        chk("flush_valid", out_valid64, 0);
        chk("flush_ready", in_ready64, 1);
        step(0, 0, 7, 0, 1, 0, 0);
        step(0, 0, 7, 0, 1, 0, 0);

        // Reset mid-stream.
        step(1, 32'hFFF00093, 7, 32'hC1, 0, 0, 0);
        step(1, 32'hFE000EE3, 7, 32'hC2, 0, 0, 0);
        step(1, 32'h0080006F, 7, 32'hC3, 1, 1, 1);
        @(posedge clk);
        #1;
        check_reset_values();
        step(0, 0, 7, 0, 1, 0, 0);

        // Randomized traffic against the queue model.
        for (int n = 0; n < 600; n++) begin
            logic [31:0] inst;
            logic [2:0]  typ;
            inst = $urandom;
            if ($urandom_range(0, 3) != 0) inst[6:0] = ops[$urandom_range(0, 13)];
            typ = ($urandom_range(0, 1) != 0) ? 3'd7 : 3'($urandom_range(0, 7));
            step($urandom_range(0, 9) < 7, inst, typ, $urandom, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 39) == 0, $urandom_range(0, 199) == 0);
        end
        step(0, 0, 7, 0, 1, 0, 0);
        step(0, 0, 7, 0, 1, 0, 0);
        step(0, 0, 7, 0, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
